uop_tt_checker: RTL and testbench
=================================

UOP_TT_CHECKER -- requirements
Module: uop_tt_checker

Interface
REQ-001 SHALL have parameter N, default 2: number of DUT inputs, legal range 1..8.
REQ-002 SHALL have parameter SETTLE, default 1: settle cycles per minterm before sampling, legal range 1..15.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous active-high reset, sampled on rising edge of clk.
REQ-005 SHALL have port start, input, 1: sweep request, sampled only in IDLE.
REQ-006 SHALL have port tt_expect, input, 2**N: expected truth table; bit i = expected DUT output for minterm i.
REQ-007 SHALL have port dut_y, input, 1: DUT output under test.
REQ-008 SHALL have port mt, output, N: registered minterm driven onto the DUT inputs, MSB = first input.
REQ-009 SHALL have port busy, output, 1: high in SETTLE and CHECK states.
REQ-010 SHALL have port done, output, 1: one-cycle pulse when sweep completes.
REQ-011 SHALL have port pass, output, 1: high when last completed sweep had zero mismatches.
REQ-012 SHALL have port fail_count, output, N+1: mismatch count of current/last sweep.
REQ-013 SHALL have port first_fail, output, N: lowest minterm that mismatched.
REQ-014 SHALL have port first_fail_valid, output, 1: first_fail holds a captured minterm.

Function
REQ-015 SHALL implement FSM states IDLE, SETTLE, CHECK, DONE.
REQ-016 IDLE with start=1 SHALL: latch tt_expect internally, set mt=0, clear fail_count, pass, first_fail, first_fail_valid, load settle counter, go to SETTLE.
REQ-017 tt_expect changes after the start edge SHALL have no effect on the running sweep.
REQ-018 SETTLE SHALL last exactly SETTLE cycles, mt held constant, then go to CHECK.
REQ-019 CHECK SHALL last one cycle and compare dut_y with latched bit tt_expect[mt].
REQ-020 On mismatch CHECK SHALL increment fail_count by 1; if first_fail_valid=0 it SHALL also load first_fail=mt and set first_fail_valid=1.
REQ-021 From CHECK with mt != 2**N-1 SHALL increment mt and return to SETTLE; with mt = 2**N-1 SHALL go to DONE without wrapping mt.
REQ-022 DONE SHALL assert done for exactly one cycle, set pass = (fail_count==0) including any mismatch from the final CHECK, then go to IDLE.
REQ-023 Latency: start sampled at edge k SHALL give done=1 in the cycle after edge k + 2**N*(SETTLE+1).
REQ-024 start while busy or in DONE SHALL be ignored; start held high in IDLE SHALL begin a new sweep each time IDLE is re-entered.
REQ-025 fail_count SHALL never wrap (max value 2**N fits N+1 bits).
REQ-026 pass, fail_count, first_fail, first_fail_valid, mt SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-027 reset=1 at a clock edge SHALL force IDLE, mt=0, busy=0, done=0, pass=0, fail_count=0, first_fail=0, first_fail_valid=0.
REQ-028 reset SHALL take priority over start and over any state, including mid-sweep; an aborted sweep SHALL NOT produce done.

Verification
REQ-029 N=2, SETTLE=1, tt_expect=4'b1001, DUT=XNOR, pulse start -> mt steps 0,1,2,3 every 2 cycles; done 8 cycles after the start edge; pass=1, fail_count=0, first_fail_valid=0.
REQ-030 Same setup, DUT=XOR -> done after 8 cycles; pass=0, fail_count=3'd4, first_fail=2'd0, first_fail_valid=1.
REQ-031 Same setup, dut_y stuck at 1 -> pass=0, fail_count=3'd2, first_fail=2'd1.
REQ-032 N=2, SETTLE=3, XNOR DUT -> each mt value held 4 cycles; done 16 cycles after start; start pulses during busy ignored (exactly one done).
REQ-033 Assert reset for one cycle while mt=2 mid-sweep -> next cycle all outputs at reset values; no done pulse; new start then completes a full sweep normally.
REQ-034 N=3, SETTLE=1, tt_expect=8'b1001_0110 (3-input XNOR), DUT=3-input XNOR, with tt_expect changed one cycle after start -> pass=1, done 16 cycles after start.

Source files
------------

// File: rtl/uop_tt_checker.sv
// uop_tt_checker
// Exhaustive truth-table checker for a small combinational DUT. On start it
// latches the expected table, then walks every minterm 0 .. 2**N-1 on mt,
// lets the DUT settle for SETTLE cycles, compares dut_y with the latched
// expectation for one cycle, and finally pulses done with a pass verdict.
//
// Ports
//   clk              : clock, all state updates on rising edge
//   reset            : synchronous active-high reset
//   start            : sweep request, honoured only when idle
//   tt_expect        : expected truth table, bit i = output for minterm i
//   dut_y            : output of the DUT under test
//   mt               : registered minterm driven onto DUT inputs (MSB = first input)
//   busy             : high while settling or checking
//   done             : one-cycle pulse when a sweep completes
//   pass             : last completed sweep had no mismatches
//   fail_count       : mismatch count of current/last sweep
//   first_fail       : lowest mismatching minterm
//   first_fail_valid : first_fail holds a captured minterm
module uop_tt_checker #(
  parameter int unsigned N      = 2,
  parameter int unsigned SETTLE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2**N-1:0]   tt_expect,
  input  logic              dut_y,
  output logic [N-1:0]      mt,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N:0]        fail_count,
  output logic [N-1:0]      first_fail,
  output logic              first_fail_valid
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [N-1:0] MT_LAST     = '1;
  localparam logic [N:0]   FAIL_MAX    = (N+1)'(2**N);
  localparam logic [3:0]   SETTLE_LOAD = 4'(SETTLE - 1);

  state_t            state;
  logic [3:0]        settle_cnt;
  logic [2**N-1:0]   tt_q;
  logic              mismatch;

  assign mismatch = (dut_y != tt_q[mt]);
  assign busy     = (state == S_SETTLE) || (state == S_CHECK);

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_IDLE;
      settle_cnt       <= '0;
      tt_q             <= '0;
      mt               <= '0;
      done             <= 1'b0;
      pass             <= 1'b0;
      fail_count       <= '0;
      first_fail       <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            tt_q             <= tt_expect;
            mt               <= '0;
            fail_count       <= '0;
            pass             <= 1'b0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
            settle_cnt       <= SETTLE_LOAD;
            state            <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          if (settle_cnt == '0) begin
            state <= S_CHECK;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end

        S_CHECK: begin
          if (mismatch) begin
            if (fail_count != FAIL_MAX) begin
              fail_count <= fail_count + (N+1)'(1);
            end
            if (!first_fail_valid) begin
              first_fail       <= mt;
              first_fail_valid <= 1'b1;
            end
          end
          if (mt == MT_LAST) begin
            // Verdict is registered alongside the done pulse, so it must fold
            // in the final minterm's result that fail_count has not yet seen.
            done  <= 1'b1;
            pass  <= (fail_count == '0) && !mismatch;
            state <= S_DONE;
          end else begin
            mt         <= mt + N'(1);
            settle_cnt <= SETTLE_LOAD;
            state      <= S_SETTLE;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uop_tt_checker.sv
module tb_uop_tt_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Stimulus side, indexed by instance: 0 = N2/S1, 1 = N2/S3, 2 = N3/S1
  logic        rst_v   [3];
  logic        start_v [3];
  logic [7:0]  tt_v    [3];
  int unsigned mode_v  [3];   // 0 chained XNOR, 1 chained XOR, 2 stuck at 1
  logic        y_v     [3];

  // Observation side, packed from per-instance nets
  logic [2:0]  mt_v   [3];
  logic        busy_v [3];
  logic        done_v [3];
  logic        pass_v [3];
  logic [3:0]  fc_v   [3];
  logic [2:0]  ff_v   [3];
  logic        ffv_v  [3];

  logic [1:0] mt_a, mt_b, ff_a, ff_b;
  logic [2:0] mt_c, ff_c, fc_a, fc_b;
  logic [3:0] fc_c;
  logic busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic pass_a, pass_b, pass_c, ffv_a, ffv_b, ffv_c;
  logic [3:0] tt_a, tt_b;
  logic [7:0] tt_c;

  always_comb begin
    tt_a = tt_v[0][3:0];
    tt_b = tt_v[1][3:0];
    tt_c = tt_v[2];
    mt_v[0] = {1'b0, mt_a};  mt_v[1] = {1'b0, mt_b};  mt_v[2] = mt_c;
    ff_v[0] = {1'b0, ff_a};  ff_v[1] = {1'b0, ff_b};  ff_v[2] = ff_c;
    fc_v[0] = {1'b0, fc_a};  fc_v[1] = {1'b0, fc_b};  fc_v[2] = fc_c;
    busy_v[0] = busy_a; busy_v[1] = busy_b; busy_v[2] = busy_c;
    done_v[0] = done_a; done_v[1] = done_b; done_v[2] = done_c;
    pass_v[0] = pass_a; pass_v[1] = pass_b; pass_v[2] = pass_c;
    ffv_v[0]  = ffv_a;  ffv_v[1]  = ffv_b;  ffv_v[2]  = ffv_c;
  end

  uop_tt_checker #(.N(2), .SETTLE(1)) u_a (
    .clk(clk), .reset(rst_v[0]), .start(start_v[0]), .tt_expect(tt_a), .dut_y(y_v[0]),
    .mt(mt_a), .busy(busy_a), .done(done_a), .pass(pass_a), .fail_count(fc_a),
    .first_fail(ff_a), .first_fail_valid(ffv_a));

  uop_tt_checker #(.N(2), .SETTLE(3)) u_b (
    .clk(clk), .reset(rst_v[1]), .start(start_v[1]), .tt_expect(tt_b), .dut_y(y_v[1]),
    .mt(mt_b), .busy(busy_b), .done(done_b), .pass(pass_b), .fail_count(fc_b),
    .first_fail(ff_b), .first_fail_valid(ffv_b));

  uop_tt_checker #(.N(3), .SETTLE(1)) u_c (
    .clk(clk), .reset(rst_v[2]), .start(start_v[2]), .tt_expect(tt_c), .dut_y(y_v[2]),
    .mt(mt_c), .busy(busy_c), .done(done_c), .pass(pass_c), .fail_count(fc_c),
    .first_fail(ff_c), .first_fail_valid(ffv_c));

  // Behavioural DUTs: gates chained from the first input (MSB of mt)
  function automatic logic dut_model(input int unsigned mode, input logic [2:0] m,
                                     input int unsigned n);
    logic r;
    if (mode == 2) return 1'b1;
    r = m[n-1];
    for (int i = int'(n) - 2; i >= 0; i--)
      r = (mode == 0) ? ~(r ^ m[i]) : (r ^ m[i]);
    return r;
  endfunction

  always_comb begin
    y_v[0] = dut_model(mode_v[0], mt_v[0], 2);
    y_v[1] = dut_model(mode_v[1], mt_v[1], 2);
    y_v[2] = dut_model(mode_v[2], mt_v[2], 3);
  end

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  typedef struct {
    int unsigned idx;
    int unsigned cyc;
    logic        pass;
    logic [3:0]  fc;
    logic [2:0]  ff;
    logic        ffv;
  } exp_t;

  exp_t sb[$];

  // Monitor: every done pulse pops one expected sweep result
  logic prev_done [3] = '{1'b0, 1'b0, 1'b0};
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done_v[i]) begin
        exp_t e;
        chk("done_width", prev_done[i], 0);
        chk("busy_in_done", busy_v[i], 0);
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("done_inst", i, e.idx);
          chk("done_cycle", cyc, e.cyc);
          chk("pass", pass_v[i], e.pass);
          chk("fail_count", fc_v[i], e.fc);
          chk("first_fail", ff_v[i], e.ff);
          chk("first_fail_valid", ffv_v[i], e.ffv);
        end
      end
      prev_done[i] <= done_v[i];
    end
  end

  task automatic chk_reset(input int unsigned idx);
    chk("rst_mt",   mt_v[idx],   0);
    chk("rst_busy", busy_v[idx], 0);
    chk("rst_done", done_v[idx], 0);
    chk("rst_pass", pass_v[idx], 0);
    chk("rst_fc",   fc_v[idx],   0);
    chk("rst_ff",   ff_v[idx],   0);
    chk("rst_ffv",  ffv_v[idx],  0);
  endtask

  // flags: bit0 alter tt_expect one cycle after start,
  //        bit1 pulse start twice while busy,
  //        bit2 reset mid-sweep when mt reaches 2 (no done expected)
  task automatic run_sweep(input int unsigned idx, input logic [7:0] tt,
                           input int unsigned mode, input int unsigned n,
                           input int unsigned s, input int unsigned len,
                           input logic e_pass, input logic [3:0] e_fc,
                           input logic [2:0] e_ff, input logic e_ffv,
                           input logic [2:0] flags);
    int unsigned k;
    exp_t e;
    mode_v[idx]  = mode;
    tt_v[idx]    = tt;
    start_v[idx] = 1'b1;
    @(posedge clk); #1;
    k = cyc;
    start_v[idx] = 1'b0;
    if (!flags[2]) begin
      e.idx = idx; e.cyc = k + len; e.pass = e_pass; e.fc = e_fc; e.ff = e_ff; e.ffv = e_ffv;
      sb.push_back(e);
    end
    for (int unsigned j = 0; j < len; j++) begin
      if (j > 0) begin
        @(posedge clk); #1;
      end
      if (flags[2] && j == 2 * (s + 1)) begin
        chk("abort_mt_before", mt_v[idx], 2);
        rst_v[idx] = 1'b1;
        @(posedge clk); #1;
        rst_v[idx] = 1'b0;
        chk_reset(idx);
        repeat (len + 4) @(posedge clk);
        #1;
        chk("abort_idle_fc", fc_v[idx], 0);
        return;
      end
      chk("busy", busy_v[idx], 1);
      chk("mt_step", mt_v[idx], j / (s + 1));
      if (flags[0] && j == 1) tt_v[idx] = ~tt;
      start_v[idx] = (flags[1] && (j == 3 || j == 7)) ? 1'b1 : 1'b0;
    end
    start_v[idx] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("idle_busy", busy_v[idx], 0);
    chk("idle_mt_hold", mt_v[idx], (1 << n) - 1);
    chk("idle_pass_hold", pass_v[idx], e_pass);
    chk("idle_fc_hold", fc_v[idx], e_fc);
    chk("idle_ff_hold", ff_v[idx], e_ff);
    chk("idle_ffv_hold", ffv_v[idx], e_ffv);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_v[i] = 1'b1; start_v[i] = 1'b0; tt_v[i] = '0; mode_v[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int unsigned i = 0; i < 3; i++) chk_reset(i);
    for (int i = 0; i < 3; i++) rst_v[i] = 1'b0;
    @(posedge clk); #1;

    //        idx tt            mode n s len pass fc     ff     ffv  flags
    run_sweep(0, 8'b0000_1001, 0, 2, 1, 8,  1'b1, 4'd0, 3'd0, 1'b0, 3'b000); // XNOR
    run_sweep(0, 8'b0000_1001, 1, 2, 1, 8,  1'b0, 4'd4, 3'd0, 1'b1, 3'b000); // XOR
    run_sweep(0, 8'b0000_1001, 2, 2, 1, 8,  1'b0, 4'd2, 3'd1, 1'b1, 3'b000); // stuck 1
    run_sweep(0, 8'b0000_1001, 0, 2, 1, 8,  1'b0, 4'd0, 3'd0, 1'b0, 3'b100); // abort
    run_sweep(0, 8'b0000_1001, 1, 2, 1, 8,  1'b0, 4'd4, 3'd0, 1'b1, 3'b000); // after abort
    run_sweep(1, 8'b0000_1001, 0, 2, 3, 16, 1'b1, 4'd0, 3'd0, 1'b0, 3'b010); // starts while busy
    run_sweep(2, 8'b1001_0110, 0, 3, 1, 16, 1'b1, 4'd0, 3'd0, 1'b0, 3'b001); // tt changed
    run_sweep(2, 8'b1001_0110, 2, 3, 1, 16, 1'b0, 4'd4, 3'd0, 1'b1, 3'b000); // stuck 1

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
